// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the register-file writeback arbiter
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;

  // Requester identifiers, used for the age flag and the round-robin pointer
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // Register x0 is hard-wired to zero; writes to it are consumed but never issued
  localparam logic [DEF_ADDR_W-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester and register-file write port bundle
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [WIDTH-1:0]  alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [WIDTH-1:0]  lsu_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;
  logic              busy;

  // Requesters plus the register file observer
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );

  // The arbiter
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

// File: rtl/wb_hold_slot.sv
// rtl/wb_hold_slot.sv - one-entry holding buffer for a writeback request
module wb_hold_slot #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              retire_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              hold_v_o,
  output logic [ADDR_W-1:0] hold_rd_o,
  output logic [WIDTH-1:0]  hold_data_o
);

  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_rd_q, hold_rd_d;
  logic [WIDTH-1:0]  hold_data_q, hold_data_d;

  // Load wins over retire so a slot can refill at the edge it empties
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (load_i) begin
      hold_v_d    = 1'b1;
      hold_rd_d   = rd_i;
      hold_data_d = data_i;
    end else if (retire_i) begin
      hold_v_d    = 1'b0;
    end
  end

  // Slot storage
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_v_o    = hold_v_q;
  assign hold_rd_o   = hold_rd_q;
  assign hold_data_o = hold_data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - age-first, round-robin arbiter for the register-file write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic              alu_v, lsu_v;
  logic [ADDR_W-1:0] alu_rd, lsu_rd;
  logic [WIDTH-1:0]  alu_data, lsu_data;
  logic              grant_alu, grant_lsu;
  logic              alu_load, lsu_load;

  // older_q: which slot loaded first when both hold; tie_q: both loaded at the same edge.
  // rr_q holds the side preferred on the next tie, so ALU wins the first tie after reset.
  logic older_q, older_d;
  logic tie_q, tie_d;
  logic rr_q, rr_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;

  wb_hold_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk(clk), .rst(rst), .load_i(alu_load), .retire_i(grant_alu),
    .rd_i(bus.alu_rd), .data_i(bus.alu_data),
    .hold_v_o(alu_v), .hold_rd_o(alu_rd), .hold_data_o(alu_data)
  );

  wb_hold_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_lsu_slot (
    .clk(clk), .rst(rst), .load_i(lsu_load), .retire_i(grant_lsu),
    .rd_i(bus.lsu_rd), .data_i(bus.lsu_data),
    .hold_v_o(lsu_v), .hold_rd_o(lsu_rd), .hold_data_o(lsu_data)
  );

  // Grant from slot state only: lone slot wins, else the older, else the rr side
  always_comb begin
    grant_alu = alu_v & ~lsu_v;
    grant_lsu = lsu_v & ~alu_v;
    if (alu_v && lsu_v) begin
      if ((tie_q ? rr_q : older_q) == REQ_ALU) grant_alu = 1'b1;
      else                                     grant_lsu = 1'b1;
    end
  end

  assign bus.alu_ready = ~rst & (~alu_v | grant_alu);
  assign bus.lsu_ready = ~rst & (~lsu_v | grant_lsu);
  assign alu_load      = bus.alu_valid & bus.alu_ready;
  assign lsu_load      = bus.lsu_valid & bus.lsu_ready;
  assign bus.busy      = ~rst & (alu_v | lsu_v);

  // Age/tie bookkeeping, rr update on ties, and the registered write port
  always_comb begin
    older_d    = older_q;
    tie_d      = tie_q;
    rr_d       = rr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_load && lsu_load) begin
      tie_d = 1'b1;
    end else if (alu_load) begin
      older_d = REQ_LSU;
      tie_d   = 1'b0;
    end else if (lsu_load) begin
      older_d = REQ_ALU;
      tie_d   = 1'b0;
    end
    if (alu_v && lsu_v && tie_q) begin
      rr_d = grant_alu ? REQ_LSU : REQ_ALU;
    end
    if (grant_alu) begin
      rf_we_d    = (alu_rd != X0_ADDR);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (grant_lsu) begin
      rf_we_d    = (lsu_rd != X0_ADDR);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = lsu_data;
    end
  end

  // Arbiter state and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      older_q    <= REQ_ALU;
      tie_q      <= 1'b0;
      rr_q       <= REQ_ALU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      older_q    <= older_d;
      tie_q      <= tie_d;
      rr_q       <= rr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for the register-file writeback arbiter
module tb_regfile_wb_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  wr_t  exp_q[$];
  logic [31:0] rf_model [32];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = data;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Scoreboard: every register-file write is popped and compared in order
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, bus.rf_waddr}, 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {59'd0, bus.rf_waddr}, {59'd0, e.rd});
        check("wr_data", {32'd0, bus.rf_wdata}, {32'd0, e.data});
      end
      rf_model[bus.rf_waddr] = bus.rf_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    set_alu(1'b1, 5'd3, 32'h1234);
    set_lsu(1'b1, 5'd6, 32'h5678);

    // 1: reset with both requesters valid
    @(negedge clk); #1;
    check("t1_alu_ready", bus.alu_ready, 0);
    check("t1_lsu_ready", bus.lsu_ready, 0);
    check("t1_busy", bus.busy, 0);
    check("t1_rf_we", bus.rf_we, 0);
    check("t1_waddr", bus.rf_waddr, 0);
    check("t1_wdata", bus.rf_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    idle(2);
    check("t1_no_write", bus.rf_we, 0);

    // 2: back-to-back ALU stream
    set_alu(1'b1, 5'd1, 32'hA); push(5'd1, 32'hA);
    #1 check("t2_ready0", bus.alu_ready, 1);
    @(negedge clk);
    check("t2_latency_we0", bus.rf_we, 0);
    set_alu(1'b1, 5'd2, 32'hB); push(5'd2, 32'hB);
    #1 check("t2_ready1", bus.alu_ready, 1);
    @(negedge clk);
    check("t2_we_c0", bus.rf_we, 1);
    set_alu(1'b1, 5'd3, 32'hC); push(5'd3, 32'hC);
    #1 check("t2_ready2", bus.alu_ready, 1);
    @(negedge clk);
    check("t2_we_c1", bus.rf_we, 1);
    set_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t2_we_c2", bus.rf_we, 1);
    @(negedge clk);
    check("t2_we_done", bus.rf_we, 0);
    idle(1);

    // 3: simultaneous loads, ALU first after reset, then rr flips to LSU
    set_alu(1'b1, 5'd4, 32'h11); set_lsu(1'b1, 5'd5, 32'h22);
    push(5'd4, 32'h11); push(5'd5, 32'h22);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
    #1 check("t3_lsu_held", bus.lsu_ready, 0);
    check("t3_alu_ready", bus.alu_ready, 1);
    @(negedge clk); #1;
    check("t3_lsu_granted", bus.lsu_ready, 1);
    idle(2);
    set_alu(1'b1, 5'd8, 32'h33); set_lsu(1'b1, 5'd9, 32'h44);
    push(5'd9, 32'h44); push(5'd8, 32'h33);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
    #1 check("t3rr_alu_held", bus.alu_ready, 0);
    check("t3rr_lsu_ready", bus.lsu_ready, 1);
    idle(3);

    // 4: LSU rd7 held while a younger ALU rd7 arrives; older must write first
    set_alu(1'b1, 5'd10, 32'h77); set_lsu(1'b1, 5'd7, 32'h55);
    push(5'd10, 32'h77);
    @(negedge clk);
    set_lsu(1'b0, 5'd0, 32'h0);
    set_alu(1'b1, 5'd7, 32'h66);
    push(5'd7, 32'h55); push(5'd7, 32'h66);
    #1 check("t4_alu_accept", bus.alu_ready, 1);
    check("t4_lsu_held", bus.lsu_ready, 0);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    #1 check("t4_alu_waits", bus.alu_ready, 0);
    check("t4_lsu_older", bus.lsu_ready, 1);
    idle(4);

    // 5: write to x0 is consumed but never issued
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0);
    #1 check("t5_busy_on", bus.busy, 1);
    @(negedge clk); #1;
    check("t5_busy_off", bus.busy, 0);
    check("t5_no_we", bus.rf_we, 0);
    idle(2);

    // 6: reset while both slots hold requests
    set_alu(1'b1, 5'd11, 32'h111); set_lsu(1'b1, 5'd12, 32'h222);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1 check("t6_rst_alu_ready", bus.alu_ready, 0);
    check("t6_rst_lsu_ready", bus.lsu_ready, 0);
    check("t6_rst_busy", bus.busy, 0);
    @(negedge clk);
    check("t6_no_we", bus.rf_we, 0);
    rst = 1'b0;
    set_alu(1'b1, 5'd13, 32'h333); set_lsu(1'b1, 5'd14, 32'h444);
    push(5'd13, 32'h333); push(5'd14, 32'h444);
    #1 check("t6_alu_ready", bus.alu_ready, 1);
    check("t6_lsu_ready", bus.lsu_ready, 1);
    check("t6_busy", bus.busy, 0);
    @(negedge clk);
    set_alu(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
    #1 check("t6_alu_first", bus.lsu_ready, 0);
    idle(4);

    check("sb_drained", exp_q.size(), 0);
    check("rf7_final", rf_model[7], 32'h66);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
